// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encoding and default widths
// Purpose: operation enum and width defaults shared by the ALU and alu_requester.
// Ports: none (package).
package alu_pkg;

  // NOP must stay at encoding 0 so that a reset bus reads as NOP.
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5
  } alu_op_t;

  localparam int ALU_DATA_W = 5;
  localparam int ALU_OUT_W  = 6;

endpackage

// File: rtl/alu_requester_if.sv
// rtl/alu_requester_if.sv - ALU op bus between requester and ALU
// Purpose: groups the ALU request (op_in/a_in/b_in/in_valid) and result (out/out_valid) signals.
// Ports (modports):
//   master - drives op_in, a_in, b_in, in_valid; receives out, out_valid (requester side)
//   slave  - receives op_in, a_in, b_in, in_valid; drives out, out_valid (ALU side)
interface alu_requester_if
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OUT_W  = ALU_OUT_W
) ();

  alu_op_t             op_in;
  logic [DATA_W-1:0]   a_in;
  logic [DATA_W-1:0]   b_in;
  logic                in_valid;
  logic [OUT_W-1:0]    out;
  logic                out_valid;

  modport master (
    output op_in, a_in, b_in, in_valid,
    input  out, out_valid
  );

  modport slave (
    input  op_in, a_in, b_in, in_valid,
    output out, out_valid
  );

endinterface

// File: rtl/alu_requester_exp_fifo.sv
// rtl/alu_requester_exp_fifo.sv - synchronous FIFO holding expected ALU results
// Purpose: stores one expected result per issued op; head is the expectation for the oldest op.
// Ports:
//   clk, rst        clock, async active-low reset (empties the FIFO)
//   push, din       write din at tail (ignored when full unless popping)
//   pop             drop head (ignored when empty)
//   head            current head entry
//   full, empty     occupancy flags
module exp_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits, so they wrap modulo DEPTH (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_requester.sv
// rtl/alu_requester.sv - issues ALU ops and checks results against expectations
// Purpose: accepts command+expected tuples, drives them to the ALU, matches returned results in order.
// Ports:
//   clk, rst                          clock, async active-low reset
//   cmd_valid/cmd_ready               upstream command handshake
//   cmd_op, cmd_a, cmd_b, cmd_exp     operation, operands, expected result
//   alu                               ALU op bus (master side)
//   res_valid, res_data, res_mismatch one pulse per retired result, with compare outcome
//   outstanding                       ops issued whose result has not returned
//   mismatch_cnt                      saturating mismatch count
//   err_spurious, err_timeout         sticky error flags
module alu_requester
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OUT_W   = ALU_OUT_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  alu_op_t                cmd_op,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  input  logic [OUT_W-1:0]       cmd_exp,
  alu_requester_if.master        alu,
  output logic                   res_valid,
  output logic [OUT_W-1:0]       res_data,
  output logic                   res_mismatch,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [15:0]            mismatch_cnt,
  output logic                   err_spurious,
  output logic                   err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic             issue;
  logic             retire;
  logic             mismatch;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] exp_head;
  logic [TO_W-1:0]  idle_cnt;

  // The FIFO and the outstanding counter move in lockstep, so its flags stand in for
  // outstanding==DEPTH / outstanding==0 without another comparator.
  assign cmd_ready = !fifo_full && !err_timeout;
  assign issue     = cmd_valid && cmd_ready;
  assign retire    = alu.out_valid && !fifo_empty;
  assign mismatch  = (alu.out != exp_head);

  exp_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (cmd_exp),
    .pop   (retire),
    .head  (exp_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue stage: the ALU has no ready, so every registered op is final.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu.in_valid <= 1'b0;
      alu.op_in    <= OP_NOP;
      alu.a_in     <= '0;
      alu.b_in     <= '0;
    end else begin
      alu.in_valid <= issue;
      alu.op_in    <= issue ? cmd_op : OP_NOP;
      alu.a_in     <= issue ? cmd_a  : '0;
      alu.b_in     <= issue ? cmd_b  : '0;
    end
  end

  // Retire/compare stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_mismatch <= 1'b0;
      mismatch_cnt <= '0;
      err_spurious <= 1'b0;
    end else begin
      res_valid    <= retire;
      res_mismatch <= retire && mismatch;
      if (retire) res_data <= alu.out;
      if (retire && mismatch && (mismatch_cnt != 16'hFFFF)) mismatch_cnt <= mismatch_cnt + 16'd1;
      if (alu.out_valid && fifo_empty) err_spurious <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      case ({issue, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Idle counter holds at TIMEOUT once reached; err_timeout stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (alu.out_valid || fifo_empty) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_W'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == TO_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
    end
  end

endmodule
